// File: rtl/vp_pkg.sv
// Shared definitions for the fetch unit and the Control block:
// datapath widths, next-PC select encodings and the fetch state type.
package vp_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;
  localparam int OP_WIDTH    = 8;

  // Next-PC select encodings driven by Control
  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection and the pc+2 adder.
// Arithmetic wraps modulo 2^PC_WIDTH. Bit 0 of the selected PC is cleared,
// so a misaligned target is truncated to a halfword boundary.
module fetch_pc_next
  import vp_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [1:0]          pcSrc_i,
  input  logic                branchTaken_i,
  input  logic [PC_WIDTH-1:0] targetAddr_i,
  output logic [PC_WIDTH-1:0] pcPlus2_o,
  output logic [PC_WIDTH-1:0] pcNext_o
);

  logic [PC_WIDTH-1:0] sel;

  // Pick sequential or target address, then force halfword alignment
  always_comb begin
    pcPlus2_o = pc_i + PC_WIDTH'(2);
    sel       = pcPlus2_o;
    unique case (pcSrc_i)
      PCSRC_SEQ:    sel = pcPlus2_o;
      PCSRC_BRANCH: sel = branchTaken_i ? targetAddr_i : pcPlus2_o;
      PCSRC_JUMP:   sel = targetAddr_i;
      PCSRC_REG:    sel = targetAddr_i;
      default:      sel = pcPlus2_o;
    endcase
    pcNext_o = sel & ~PC_WIDTH'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> EXEC -> FETCH ...
// FETCH holds memReq/memAddr until memAck, captures the word into IR.
// EXEC presents op/imm with instrValid until execDone, then loads the next PC
// and re-enters FETCH the following cycle (2 cycles/instruction minimum).
module fetch_unit
  import vp_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   memReq,
  output logic [PC_WIDTH-1:0]    memAddr,
  input  logic [INSTR_WIDTH-1:0] memRdata,
  input  logic                   memAck,
  output logic [OP_WIDTH-1:0]    op,
  output logic [OP_WIDTH-1:0]    imm,
  output logic                   instrValid,
  input  logic [1:0]             pcSrc,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    targetAddr,
  input  logic                   execDone,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pcPlus2
);

  fetch_state_e           state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic                   memReq_q;
  logic [PC_WIDTH-1:0]    memAddr_q;
  logic                   instrValid_q;
  logic [PC_WIDTH-1:0]    pc_d;

  fetch_pc_next u_pc_next (
    .pc_i          (pc_q),
    .pcSrc_i       (pcSrc),
    .branchTaken_i (branchTaken),
    .targetAddr_i  (targetAddr),
    .pcPlus2_o     (pcPlus2),
    .pcNext_o      (pc_d)
  );

  // Fetch FSM with registered handshake outputs; ack/done outside their
  // owning state fall through to the default hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FS_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      memReq_q     <= 1'b0;
      memAddr_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          state_q   <= FS_FETCH;
          memReq_q  <= 1'b1;
          memAddr_q <= pc_q;
        end
        FS_FETCH: begin
          if (memAck) begin
            ir_q         <= memRdata;
            memReq_q     <= 1'b0;
            instrValid_q <= 1'b1;
            state_q      <= FS_EXEC;
          end
        end
        FS_EXEC: begin
          if (execDone) begin
            pc_q         <= pc_d;
            memAddr_q    <= pc_d;
            memReq_q     <= 1'b1;
            instrValid_q <= 1'b0;
            state_q      <= FS_FETCH;
          end
        end
        default: begin
          state_q      <= FS_IDLE;
          memReq_q     <= 1'b0;
          instrValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign memReq     = memReq_q;
  assign memAddr    = memAddr_q;
  assign instrValid = instrValid_q;
  assign op         = ir_q[INSTR_WIDTH-1 -: OP_WIDTH];
  assign imm        = ir_q[OP_WIDTH-1:0];
  assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change and outputs are checked on
// the falling edge; the DUT samples on the rising edge.
module tb_fetch_unit;
  import vp_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memReq;
  logic [15:0] memAddr;
  logic [15:0] memRdata;
  logic        memAck;
  logic [7:0]  op;
  logic [7:0]  imm;
  logic        instrValid;
  logic [1:0]  pcSrc;
  logic        branchTaken;
  logic [15:0] targetAddr;
  logic        execDone;
  logic [15:0] pc;
  logic [15:0] pcPlus2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memRdata    (memRdata),
    .memAck      (memAck),
    .op          (op),
    .imm         (imm),
    .instrValid  (instrValid),
    .pcSrc       (pcSrc),
    .branchTaken (branchTaken),
    .targetAddr  (targetAddr),
    .execDone    (execDone),
    .pc          (pc),
    .pcPlus2     (pcPlus2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction word with ack in the current FETCH cycle
  task automatic give_word(input logic [15:0] w);
    memRdata = w;
    memAck   = 1'b1;
    @(negedge clock);
    memAck   = 1'b0;
  endtask

  // Complete the current EXEC with the given next-PC request
  task automatic done(input logic [1:0] src, input logic bt, input logic [15:0] tgt);
    pcSrc       = src;
    branchTaken = bt;
    targetAddr  = tgt;
    execDone    = 1'b1;
    @(negedge clock);
    execDone    = 1'b0;
    targetAddr  = 16'hBEEF;
    pcSrc       = PCSRC_JUMP;
    branchTaken = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; memRdata = 16'h0; memAck = 1'b1;
    pcSrc = '0; branchTaken = 1'b0; targetAddr = '0; execDone = 1'b1;

    // Reset state, with ack and done asserted throughout reset
    repeat (2) @(negedge clock);
    chk("rst_memReq", 16'(memReq), 16'h0);
    chk("rst_valid", 16'(instrValid), 16'h0);
    chk("rst_addr", memAddr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", {op, imm}, 16'h0000);

    // Release with ack still high: the IDLE cycle must ignore it
    execDone = 1'b0;
    memRdata = 16'hDEAD;
    reset_n  = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    chk("post_rst_ir", {op, imm}, 16'h0000);
    chk("post_rst_valid", 16'(instrValid), 16'h0);

    // memReq held 4 cycles at 0x0000, ack on the 4th
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 16'(memReq), 16'h1);
      chk("wait_addr", memAddr, 16'h0000);
      @(negedge clock);
    end
    chk("wait_req4", 16'(memReq), 16'h1);
    chk("wait_addr4", memAddr, 16'h0000);
    give_word(16'h1E40);
    chk("first_valid", 16'(instrValid), 16'h1);
    chk("first_ir", {op, imm}, 16'h1E40);
    chk("first_req_low", 16'(memReq), 16'h0);

    // Spurious ack in EXEC: IR and state unchanged
    memRdata = 16'hFFFF;
    memAck   = 1'b1;
    @(negedge clock);
    memAck   = 1'b0;
    chk("spur_ack_ir", {op, imm}, 16'h1E40);
    chk("spur_ack_valid", 16'(instrValid), 16'h1);
    chk("spur_ack_req", 16'(memReq), 16'h0);

    // Misaligned jump target truncated to 0x0010
    done(PCSRC_JUMP, 1'b0, 16'h0011);
    chk("jmp_align_addr", memAddr, 16'h0010);
    chk("jmp_align_req", 16'(memReq), 16'h1);
    chk("jmp_align_pc", pc, 16'h0010);

    // Spurious execDone in FETCH: no change
    execDone = 1'b1;
    @(negedge clock);
    execDone = 1'b0;
    chk("spur_done_req", 16'(memReq), 16'h1);
    chk("spur_done_addr", memAddr, 16'h0010);
    chk("spur_done_valid", 16'(instrValid), 16'h0);

    // Sequential at 0x0010
    give_word(16'hA55A);
    chk("seq_ir", {op, imm}, 16'hA55A);
    chk("seq_plus2", pcPlus2, 16'h0012);
    done(PCSRC_SEQ, 1'b1, 16'h0300);
    chk("seq_addr", memAddr, 16'h0012);

    // Branch taken at 0x0020
    give_word(16'h0102);
    done(PCSRC_JUMP, 1'b0, 16'h0020);
    give_word(16'h0203);
    done(PCSRC_BRANCH, 1'b1, 16'h0101);
    chk("br_taken_addr", memAddr, 16'h0100);

    // Branch not taken at 0x0020
    give_word(16'h0304);
    done(PCSRC_JUMP, 1'b0, 16'h0020);
    give_word(16'h0405);
    done(PCSRC_BRANCH, 1'b0, 16'h0101);
    chk("br_not_addr", memAddr, 16'h0022);

    // Jump-register
    give_word(16'h0506);
    done(PCSRC_REG, 1'b0, 16'h1234);
    chk("jr_addr", memAddr, 16'h1234);

    // Wrap at 0xFFFE
    give_word(16'h0607);
    done(PCSRC_JUMP, 1'b0, 16'hFFFE);
    give_word(16'h0708);
    chk("wrap_plus2", pcPlus2, 16'h0000);
    done(PCSRC_SEQ, 1'b0, 16'h5555);
    chk("wrap_addr", memAddr, 16'h0000);
    chk("wrap_req", 16'(memReq), 16'h1);

    // Asynchronous reset mid-EXEC
    give_word(16'h0809);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_exec_valid", 16'(instrValid), 16'h0);
    chk("rst_exec_ir", {op, imm}, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Asynchronous reset mid-FETCH at 0x0040
    give_word(16'h090A);
    done(PCSRC_JUMP, 1'b0, 16'h0040);
    chk("pre_rst_addr", memAddr, 16'h0040);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_fetch_req", 16'(memReq), 16'h0);
    chk("rst_fetch_addr", memAddr, 16'h0000);
    chk("rst_fetch_pc", pc, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("restart_req", 16'(memReq), 16'h1);
    chk("restart_addr", memAddr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 memReq  out  1  instruction-memory read request.
REQ-004 memAddr  out  16  byte address of the instruction being fetched.
REQ-005 memRdata  in  16  instruction word returned by memory.
REQ-006 memAck  in  1  memory read-data-valid strobe, one cycle per request.
REQ-007 op  out  8  opcode to Control, equal to IR[15:8].
REQ-008 imm  out  8  operand/immediate field, equal to IR[7:0].
REQ-009 instrValid  out  1  op/imm hold a fetched instruction and are stable.
REQ-010 pcSrc  in  2  next-PC select from Control: 0 = sequential, 1 = branch, 2 = jump, 3 = jump-register.
REQ-011 branchTaken  in  1  branch condition result from the datapath, used only when pcSrc = 1.
REQ-012 targetAddr  in  16  branch, jump or register target from the datapath.
REQ-013 execDone  in  1  the current instruction has completed execution.
REQ-014 pc  out  16  address of the current instruction.
REQ-015 pcPlus2  out  16  pc + 2, the return address for jal / writeRa.

Function
REQ-016 The block SHALL implement three states:
- IDLE: entered on reset; SHALL move to FETCH on the next clock edge.
- FETCH: SHALL assert memReq = 1 and memAddr = pc; on memAck = 1 SHALL load memRdata into IR and move to EXEC.
- EXEC: SHALL assert instrValid = 1; on execDone = 1 SHALL load the next PC and move to FETCH.
REQ-017 memReq SHALL stay high, with memAddr stable, every cycle until memAck arrives, however long the wait.
REQ-018 memRdata SHALL be sampled only when state = FETCH and memAck = 1; memAck in IDLE or EXEC SHALL be ignored.
REQ-019 execDone outside EXEC SHALL be ignored.
REQ-020 Latency: memAck in cycle N gives instrValid = 1 in cycle N+1; execDone in cycle M gives memReq = 1 with the new pc in cycle M+1.
REQ-021 Minimum throughput SHALL be 2 cycles per instruction (ack in the first FETCH cycle, done in the first EXEC cycle).
REQ-022 The next PC SHALL be:
- pcSrc 0: pc+2.
- pcSrc 1: targetAddr if branchTaken, otherwise pc+2.
- pcSrc 2 or 3: targetAddr.
REQ-023 All PC arithmetic SHALL be 16-bit modulo 2^16: 0xFFFE + 2 = 0x0000, with no flag.
REQ-024 Bit 0 of every loaded PC SHALL be forced to 0, so a misaligned targetAddr is truncated.
REQ-025 op, imm and pcPlus2 SHALL be registered or derived from registers only, never combinational from memRdata.
REQ-026 pcSrc, branchTaken and targetAddr SHALL be sampled only in the cycle where state = EXEC and execDone = 1.
REQ-027 op and imm SHALL hold their last value outside EXEC; consumers SHALL qualify them with instrValid.

Reset
REQ-028 While reset_n = 0 the block SHALL force: state = IDLE, pc = 0x0000, IR = 0x0000, memReq = 0, instrValid = 0, memAddr = 0x0000.
REQ-029 These values SHALL take effect asynchronously, including in the middle of a fetch or mid-EXEC.
REQ-030 A memAck arriving during reset or in the cycle after deassertion SHALL be ignored.
REQ-031 The first fetch after reset SHALL be from address 0x0000.

Structure
REQ-032 Shared package vp_pkg SHALL hold:
- PC_WIDTH = 16, INSTR_WIDTH = 16, OP_WIDTH = 8.
- PCSRC_SEQ = 0, PCSRC_BRANCH = 1, PCSRC_JUMP = 2, PCSRC_REG = 3, shared with Control.
- The fetch state enumeration.
REQ-033 The next-PC mux and adder SHALL be a combinational sub-module, fetch_pc_next; all state SHALL live in fetch_unit.

Verification
REQ-034 Reset, then memAck held low for 3 cycles, then memRdata = 0x1E40 with memAck: memReq high 4 cycles at memAddr 0x0000; next cycle instrValid = 1, op = 0x1E, imm = 0x40.
REQ-035 pcSrc = 0 and execDone at pc 0x0010: next fetch at memAddr 0x0012; pcPlus2 = 0x0012 during EXEC.
REQ-036 pcSrc = 1, targetAddr = 0x0101 at pc 0x0020:
- branchTaken = 1: next fetch at 0x0100.
- branchTaken = 0: next fetch at 0x0022.
REQ-037 pc = 0xFFFE, pcSrc = 0, execDone: next fetch at 0x0000.
REQ-038 Spurious memAck and execDone in the wrong states: no state change and IR unchanged.
REQ-039 reset_n pulsed low mid-FETCH at pc 0x0040: memReq drops immediately; after release the fetch restarts at 0x0000.
